// File: rtl/dm_pkg.sv
// dm_pkg: access-type codes, FSM states, error causes and the legality check
// shared by the data-memory controller and its alignment unit.
// Latency: none (declarations only). Backpressure: not applicable.
package dm_pkg;

  // Access-type codes as presented on req_type; 101..111 are illegal.
  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  // Why an access was rejected.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  // Classify an access from its type and the two low address bits.
  function automatic logic [1:0] dm_err_cause(input logic [2:0] typ,
                                              input logic [1:0] lo);
    case (typ)
      DM_WORD:           return (lo != 2'b00) ? ERR_MISALIGN : ERR_NONE;
      DM_HALF, DM_HALFU: return lo[0] ? ERR_MISALIGN : ERR_NONE;
      DM_BYTE, DM_BYTEU: return ERR_NONE;
      default:           return ERR_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// dm_ctrl_if: request/response bundle between the load/store stage (master)
// and the data memory (slave). Ports: req_* request channel, rsp_* response
// channel, busy status. Latency/backpressure are set by the slave.
interface dm_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_type;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dm_lsu_align.sv
// dm_lsu_align: legality check, byte-lane write enables/data and load extension.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: typ/addr_lo/we/wdata/rword in; err/be/wbytes/rdata out. rword and
// wbytes are little-endian relative to the access address (lane 0 = addr+0).
module dm_lsu_align
  import dm_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wbytes,
  output logic [31:0] rdata
);

  logic [1:0] cause;

  always_comb begin
    cause  = dm_err_cause(typ, addr_lo);
    err    = (cause != ERR_NONE);
    be     = 4'b0000;
    wbytes = 32'h0;
    rdata  = 32'h0;
    if (!err) begin
      case (typ)
        DM_WORD: begin
          be     = 4'b1111;
          wbytes = wdata;
          rdata  = rword;
        end
        DM_HALF, DM_HALFU: begin
          be     = 4'b0011;
          wbytes = {16'h0, wdata[15:0]};
          rdata  = (typ == DM_HALF) ? {{16{rword[15]}}, rword[15:0]}
                                    : {16'h0, rword[15:0]};
        end
        DM_BYTE, DM_BYTEU: begin
          be     = 4'b0001;
          wbytes = {24'h0, wdata[7:0]};
          rdata  = (typ == DM_BYTE) ? {{24{rword[7]}}, rword[7:0]}
                                    : {24'h0, rword[7:0]};
        end
        default: ;
      endcase
      // Stores return zero data; loads never write.
      if (we) rdata = 32'h0;
      else    be    = 4'b0000;
    end
  end

endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: byte-addressable data memory behind a valid/ready request/response pair.
// Latency: access and rsp_valid at WAIT_STATES+1 edges after acceptance.
// Backpressure: one access in flight; req_ready low until the response is taken.
// Ports: Clk_CPU, rstn (async, active-low), bus (slave side of dm_ctrl_if).
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input logic      Clk_CPU,
  input logic      rstn,
  dm_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  dm_state_e         state_q, state_d;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        type_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [7:0]        mem [DEPTH];

  logic        accept;
  logic        access;
  logic [31:0] rword;
  logic [31:0] wbytes;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic        acc_err;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;
  assign access = (state_q == ST_WAIT) && (wait_cnt == 4'd0);

  // Four bytes starting at the access address; lanes past an aligned access
  // may wrap but are never used.
  assign rword = {mem[addr_q + ADDR_W'(3)], mem[addr_q + ADDR_W'(2)],
                  mem[addr_q + ADDR_W'(1)], mem[addr_q]};

  dm_lsu_align u_align (
    .typ     (type_q),
    .addr_lo (addr_q[1:0]),
    .we      (we_q),
    .wdata   (wdata_q),
    .rword   (rword),
    .err     (acc_err),
    .be      (be),
    .wbytes  (wbytes),
    .rdata   (ld_data)
  );

  always_ff @(posedge Clk_CPU or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid)       state_d = ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0)    state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready)       state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge Clk_CPU or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      type_q   <= 3'b000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        type_q   <= bus.req_type;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state_q == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (access) begin
        rdata_q <= ld_data;
        err_q   <= acc_err;
      end
    end
  end

  // Storage: reset reloads the identity pattern, so a store cut off by reset
  // leaves no trace.
  always_ff @(posedge Clk_CPU or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
    end else if (access) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[addr_q + ADDR_W'(k)] <= wbytes[k*8 +: 8];
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised byte-addressable data memory with a valid/ready request/response handshake, configurable wait states and misalignment/illegal-type error reporting. It sits between the CPU load/store stage and data storage. Memory depth is set by parameter. Accesses are multi-cycle, so the pipeline stalls on the handshake instead of relying on a same-edge memory update.

## Interface
- ADDR_W, 8, byte address width; memory holds 2^ADDR_W bytes
- WAIT_STATES, 1, extra cycles between request acceptance and the access (0..15)
- Clk_CPU  in  1  clock, rising edge
- rstn  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; low bytes are used for byte/halfword
- req_type  in  3  DMType: 000 word, 001 halfword, 010 halfword_unsigned, 011 byte, 100 byte_unsigned; 101–111 illegal
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal type
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on req_valid && req_ready. Latch we/addr/wdata/type and load wait_cnt = WAIT_STATES.
  - WAIT: decrement wait_cnt while it is nonzero.
  - WAIT -> RESP when wait_cnt == 0. The access executes on this edge.
  - RESP -> IDLE on rsp_valid && rsp_ready.
- req_ready = (state == IDLE). Requests offered in WAIT or RESP are ignored; nothing is queued.
- Alignment rules:
  - Word requires addr[1:0] == 0.
  - Halfword requires addr[0] == 0.
  - Byte accesses are legal at any address.
- On a violation or an illegal type: rsp_err = 1, no memory write, rsp_rdata = 0.
- Stores:
  - Byte: writes wdata[7:0].
  - Halfword: writes wdata[15:0], little-endian.
  - Word: writes wdata[31:0], little-endian.
  - rsp_rdata = 0.
- Loads: little-endian assembly.
  - byte and halfword are sign-extended from bit 7 and bit 15 respectively.
  - byte_unsigned and halfword_unsigned are zero-extended.
- Aligned accesses never cross the top of memory, so there is no address wrap.
- rsp_rdata and rsp_err are registered on the WAIT->RESP edge and held stable throughout RESP.

## Timing
- Reset:
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; busy = 0; wait_cnt = 0.
  - Memory byte i = i[7:0].
- Request accepted at edge E0. The access executes, and rsp_valid rises, at edge E0 + WAIT_STATES + 1.
- The response handshake completes at edge E1. req_ready rises after E1, so the earliest next acceptance is edge E1 + 1.
- rsp_ready may be held low indefinitely. The response stays stable and no further request is accepted.
- rsp_ready high before rsp_valid has no effect.
- Reset asserted mid-operation (WAIT or RESP):
  - Takes effect immediately; the in-flight store is discarded and any pending response is dropped.
  - Memory is re-initialised.
- Simultaneous req_valid and response handshake in RESP: the request is not accepted in that cycle.

## Structure
- Package dm_pkg holds the DMType codes, the FSM state enum and the error-cause localparams.
- Sub-module dm_lsu_align (combinational) does the following:
  - Checks alignment and type legality.
  - Produces per-byte write enables and write data.
  - Extracts and extends load data from the four addressed bytes.
- dm_ctrl holds the memory array, the FSM, wait_cnt and the response registers.

## Test plan
- Reset, then load word at 0x04 with WAIT_STATES = 1 -> rsp_valid 2 edges after accept; rsp_rdata = 0x07060504; rsp_err = 0.
- Load byte at 0x80 -> 0xFFFFFF80; load byte_unsigned at 0x80 -> 0x00000080; load halfword at 0xFE -> 0xFFFFFFFE.
- Store halfword 0x1234ABCD at 0x10, then load word at 0x10 -> 0x1312ABCD. Store byte 0x55 at 0x11, then load halfword_unsigned at 0x10 -> 0x000055CD.
- Load word at 0x02, then store halfword at 0x03, then a request with type 110 -> each returns rsp_err = 1 and rsp_rdata = 0; a word load at 0x00 afterwards reads 0x03020100.
- Hold rsp_ready low for 3 cycles with req_valid high -> rsp_valid, rsp_rdata and rsp_err are stable; req_ready = 0; the second request is accepted only on the edge after the handshake.
- WAIT_STATES = 3: store word 0xDEADBEEF at 0x20, then pulse rstn low during WAIT -> after reset, load word at 0x20 -> 0x23222120.
